// File: rtl/openhw_cnt_sched.sv
// Round-robin scheduler sharing one clz/ctz/cpop count unit among NREQ requesters.
// Optional per-requester grant counters are built when CNT_SCHED_PERF_EN is defined.
module openhw_cnt_sched #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned NREQ  = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     Flush,
   input  logic [NREQ-1:0]          ReqValid,
   output logic [NREQ-1:0]          ReqReady,
   input  logic [NREQ*WIDTH-1:0]    ReqA,
   input  logic [NREQ*2-1:0]        ReqB,
   input  logic [NREQ-1:0]          ReqW64,
   output logic [WIDTH-1:0]         CntA,
   output logic [WIDTH-1:0]         CntRevA,
   output logic [1:0]               CntB,
   output logic                     CntW64,
   input  logic [WIDTH-1:0]         CntResult,
   output logic                     RspValid,
   input  logic                     RspReady,
   output logic [$clog2(NREQ)-1:0]  RspId,
   output logic [WIDTH-1:0]         RspResult,
   output logic [NREQ*32-1:0]       PerfGrantCnt
);

   localparam int unsigned IDW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   idx_q;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   nxt_ptr;
   logic             gnt_any;
   logic             accept;
   logic             hs;
   logic [WIDTH-1:0] sel_a;
   logic [1:0]       sel_b;
   logic             sel_w64;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, round-robin pick and one-hot ready
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      cand     = '0;
      hs       = 1'b0;
      ReqReady = '0;
      case (state_q)
         IDLE: accept = 1'b1;
         EXEC: state_d = RESP;
         RESP: begin
            if (RspReady) begin
               accept  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (Flush || !reset_n) begin
         accept  = 1'b0;
         state_d = IDLE;
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(ptr_q) + k) % NREQ);
         if (!gnt_any && ReqValid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (accept && gnt_any) begin
         hs                = 1'b1;
         state_d           = EXEC;
         ReqReady[gnt_idx] = 1'b1;
      end
   end

   // Operand select for the granted requester and the pointer that follows it
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_w64 = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (IDW'(k) == gnt_idx) begin
            sel_a   = ReqA[k*WIDTH +: WIDTH];
            sel_b   = ReqB[k*2 +: 2];
            sel_w64 = ReqW64[k];
         end
      end
      nxt_ptr = IDW'((32'(gnt_idx) + 32'd1) % NREQ);
   end

   // Operand capture on handshake and response register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         CntA      <= '0;
         CntB      <= '0;
         CntW64    <= 1'b0;
         idx_q     <= '0;
         ptr_q     <= '0;
         RspValid  <= 1'b0;
         RspId     <= '0;
         RspResult <= '0;
      end else begin
         if (hs) begin
            CntA   <= sel_a;
            CntB   <= sel_b;
            CntW64 <= (WIDTH == 64) ? sel_w64 : 1'b0;
            idx_q  <= gnt_idx;
            ptr_q  <= nxt_ptr;
         end
         if (Flush) begin
            RspValid <= 1'b0;
         end else if (state_q == EXEC) begin
            RspValid  <= 1'b1;
            RspId     <= idx_q;
            RspResult <= CntResult;
         end else if ((state_q == RESP) && RspReady) begin
            RspValid <= 1'b0;
         end
      end
   end

   // Bit-reversed operand for the count unit
   always_comb begin
      CntRevA = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         CntRevA[i] = CntA[WIDTH-1-i];
      end
   end

`ifdef CNT_SCHED_PERF_EN
   logic [NREQ-1:0][31:0] perf_q;

   // Per-requester grant counters; wrap naturally, untouched by Flush
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_q <= '0;
      end else if (hs) begin
         perf_q[gnt_idx] <= perf_q[gnt_idx] + 32'd1;
      end
   end

   assign PerfGrantCnt = perf_q;
`else
   assign PerfGrantCnt = '0;
`endif

endmodule

// File: tb/tb_openhw_cnt_sched.sv
// Self-checking bench for openhw_cnt_sched: directed table, hand sequences, randomized model run.
module tb_openhw_cnt_sched;

   localparam int unsigned W  = 64;
   localparam int unsigned N  = 2;
   localparam int unsigned AW = N*W;
   localparam int unsigned BW = N*2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            Flush;
   logic [N-1:0]    ReqValid;
   logic [N-1:0]    ReqReady;
   logic [AW-1:0]   ReqA;
   logic [BW-1:0]   ReqB;
   logic [N-1:0]    ReqW64;
   logic [W-1:0]    CntA;
   logic [W-1:0]    CntRevA;
   logic [1:0]      CntB;
   logic            CntW64;
   logic [W-1:0]    CntResult;
   logic            RspValid;
   logic            RspReady;
   logic [$clog2(N)-1:0] RspId;
   logic [W-1:0]    RspResult;
   logic [N*32-1:0] PerfGrantCnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          id;
      logic [63:0] a;
      logic [1:0]  b;
      logic        w;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[8];

   openhw_cnt_sched #(.WIDTH(W), .NREQ(N)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .Flush        (Flush),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .ReqA         (ReqA),
      .ReqB         (ReqB),
      .ReqW64       (ReqW64),
      .CntA         (CntA),
      .CntRevA      (CntRevA),
      .CntB         (CntB),
      .CntW64       (CntW64),
      .CntResult    (CntResult),
      .RspValid     (RspValid),
      .RspReady     (RspReady),
      .RspId        (RspId),
      .RspResult    (RspResult),
      .PerfGrantCnt (PerfGrantCnt)
   );

   always #5 clk = ~clk;

   // Count-unit stub: W64=1 selects the 32-bit word form
   function automatic logic [63:0] cnt_model(input logic [63:0] a, input logic [1:0] b, input logic w);
      int n;
      int r;
      n = w ? 32 : 64;
      r = 0;
      if (b[1]) begin
         for (int i = 0; i < n; i++) r += int'(a[i]);
      end else if (b[0]) begin
         r = n;
         for (int i = n-1; i >= 0; i--) if (a[i]) r = i;
      end else begin
         r = n;
         for (int i = 0; i < n; i++) if (a[i]) r = n-1-i;
      end
      return 64'(r);
   endfunction

   assign CntResult = cnt_model(CntA, CntB, CntW64);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops();
      ReqA   = AW'({$urandom, $urandom, $urandom, $urandom});
      ReqB   = BW'($urandom);
      ReqW64 = N'($urandom);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      Flush    = 1'b0;
      RspReady = 1'b0;
      ReqValid = '1;
      #1;
      chk("rst_req_ready", 64'(ReqReady), 64'd0);
      chk("rst_rsp_valid", 64'(RspValid), 64'd0);
      chk("rst_rsp_id",    64'(RspId),    64'd0);
      chk("rst_rsp_res",   RspResult,     64'd0);
      chk("rst_cnt_a",     CntA,          64'd0);
      chk("rst_cnt_bw",    64'({CntB, CntW64}), 64'd0);
      chk("rst_perf",      PerfGrantCnt,  64'd0);
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      ReqValid = '0;
   endtask

   // Single isolated operation from IDLE, then drained back to IDLE
   task automatic run_op(input vec_t v);
      logic [N-1:0] exp_rr;
      rand_ops();
      ReqA[v.id*W +: W] = v.a;
      ReqB[v.id*2 +: 2] = v.b;
      ReqW64[v.id]      = v.w;
      ReqValid          = '0;
      ReqValid[v.id]    = 1'b1;
      RspReady          = 1'b0;
      exp_rr            = '0;
      exp_rr[v.id]      = 1'b1;
      #1;
      chk("tbl_grant", 64'(ReqReady), 64'(exp_rr));
      tick();
      ReqValid = '1;
      rand_ops();
      #1;
      chk("tbl_exec_no_ready", 64'(ReqReady), 64'd0);
      chk("tbl_exec_no_rsp",   64'(RspValid), 64'd0);
      chk("tbl_cnt_a",         CntA,          v.a);
      chk("tbl_cnt_bw",        64'({CntB, CntW64}), 64'({v.b, v.w}));
      ReqValid = '0;
      tick();
      chk("tbl_rsp_valid", 64'(RspValid), 64'd1);
      chk("tbl_rsp_res",   RspResult,     v.exp);
      chk("tbl_rsp_id",    64'(RspId),    64'(v.id));
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;
      chk("tbl_rsp_drop", 64'(RspValid), 64'd0);
   endtask

   task automatic random_phase(input int ncyc);
      bit           ex_p, rs_p;
      int           ex_id, rs_id, ptr, g;
      logic [63:0]  ex_a, ex_res, rs_res, rev, exp_perf;
      logic [N-1:0] exp_rr;
      int unsigned  grants[N];
      ex_p = 0; rs_p = 0; ex_id = 0; rs_id = 0; ptr = 0;
      ex_a = '0; ex_res = '0; rs_res = '0;
      for (int i = 0; i < N; i++) grants[i] = 0;
      for (int c = 0; c < ncyc; c++) begin
         rand_ops();
         ReqValid = N'($urandom);
         RspReady = ($urandom_range(0, 9) < 6);
         Flush    = ($urandom_range(0, 19) == 0);
         #1;
         chk("rnd_rsp_valid", 64'(RspValid), 64'(rs_p));
         if (rs_p) begin
            chk("rnd_rsp_id",  64'(RspId), 64'(rs_id));
            chk("rnd_rsp_res", RspResult,  rs_res);
         end
         if (ex_p) begin
            rev = {<<{ex_a}};
            chk("rnd_cnt_a",   CntA,    ex_a);
            chk("rnd_cnt_rev", CntRevA, rev);
         end
         exp_perf = '0;
`ifdef CNT_SCHED_PERF_EN
         for (int i = 0; i < N; i++) exp_perf[i*32 +: 32] = grants[i];
`endif
         chk("rnd_perf", PerfGrantCnt, exp_perf);
         g = -1;
         if (!Flush && !ex_p && (!rs_p || RspReady)) begin
            for (int k = 0; k < N; k++) begin
               int j;
               j = (ptr + k) % N;
               if (g < 0 && ReqValid[j]) g = j;
            end
         end
         exp_rr = '0;
         if (g >= 0) exp_rr[g] = 1'b1;
         chk("rnd_req_ready", 64'(ReqReady), 64'(exp_rr));
         tick();
         if (Flush) begin
            ex_p = 0;
            rs_p = 0;
         end else begin
            if (rs_p && RspReady) rs_p = 0;
            if (ex_p) begin
               rs_p = 1; rs_id = ex_id; rs_res = ex_res; ex_p = 0;
            end
            if (g >= 0) begin
               ex_p   = 1;
               ex_id  = g;
               ex_a   = ReqA[g*W +: W];
               ex_res = cnt_model(ex_a, ReqB[g*2 +: 2], ReqW64[g]);
               ptr    = (g + 1) % N;
               grants[g]++;
            end
         end
      end
      Flush    = 1'b0;
      ReqValid = '0;
   endtask

   initial begin
      int          exp_rr_seq[6];
      int          exp_rv_seq[6];
      int          exp_id_seq[6];
      logic [63:0] hold_res;
      logic [63:0] exp3;

      tbl[0] = '{0, 64'h0000_0000_0000_00F0, 2'b00, 1'b0, 64'd56};
      tbl[1] = '{1, 64'hFFFF_FFFF_0000_FFFF, 2'b10, 1'b1, 64'd16};
      tbl[2] = '{1, 64'hFFFF_FFFF_0000_FFFF, 2'b01, 1'b0, 64'd0};
      tbl[3] = '{0, 64'h0000_0000_0000_0000, 2'b00, 1'b0, 64'd64};
      tbl[4] = '{1, 64'h8000_0000_0000_0000, 2'b00, 1'b0, 64'd0};
      tbl[5] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'd64};
      tbl[6] = '{1, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 64'd63};
      tbl[7] = '{0, 64'h0000_0001_0000_0000, 2'b01, 1'b1, 64'd32};

      reset_n = 1'b0; Flush = 1'b0; RspReady = 1'b0; ReqValid = '0;
      ReqA = '0; ReqB = '0; ReqW64 = '0;

      do_reset();
      for (int i = 0; i < 8; i++) run_op(tbl[i]);

      // Three grants to requester 1 feed its grant counter
      do_reset();
      for (int i = 0; i < 3; i++) run_op(tbl[1]);
`ifdef CNT_SCHED_PERF_EN
      exp3 = {32'd3, 32'd0};
`else
      exp3 = '0;
`endif
      chk("perf_three_grants", PerfGrantCnt, exp3);

      // Both requesters held valid with a ready consumer: grants alternate
      do_reset();
      exp_rr_seq = '{1, 0, 2, 0, 1, 0};
      exp_rv_seq = '{0, 0, 1, 0, 1, 0};
      exp_id_seq = '{0, 0, 0, 0, 1, 0};
      ReqValid = '1;
      RspReady = 1'b1;
      for (int c = 0; c < 6; c++) begin
         rand_ops();
         #1;
         chk("rr_ready", 64'(ReqReady), 64'(exp_rr_seq[c]));
         chk("rr_rsp_valid", 64'(RspValid), 64'(exp_rv_seq[c]));
         if (exp_rv_seq[c] != 0) chk("rr_rsp_id", 64'(RspId), 64'(exp_id_seq[c]));
         tick();
      end
      chk("rr_last_valid", 64'(RspValid), 64'd1);
      chk("rr_last_id",    64'(RspId),    64'd0);
      ReqValid = '0;
      tick();

      // Response held while the consumer stalls, then same-cycle regrant
      do_reset();
      rand_ops();
      ReqA[W-1:0] = 64'h0000_0000_0000_00F0;
      ReqB[1:0]   = 2'b00;
      ReqValid    = 2'b01;
      tick();
      ReqValid = '0;
      tick();
      hold_res = RspResult;
      chk("stall_first_res", hold_res, 64'd56);
      ReqValid = 2'b01;
      for (int c = 0; c < 5; c++) begin
         rand_ops();
         #1;
         chk("stall_valid", 64'(RspValid), 64'd1);
         chk("stall_res",   RspResult,     hold_res);
         chk("stall_id",    64'(RspId),    64'd0);
         chk("stall_ready", 64'(ReqReady), 64'd0);
         tick();
      end
      RspReady = 1'b1;
      #1;
      chk("stall_regrant", 64'(ReqReady), 64'd1);
      tick();
      RspReady = 1'b0;
      ReqValid = '0;
      chk("stall_exec_valid", 64'(RspValid), 64'd0);
      tick();
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;

      // Flush in EXEC drops the op and leaves the pointer after req0
      do_reset();
      ReqValid = 2'b01;
      tick();
      ReqValid = 2'b11;
      Flush    = 1'b1;
      RspReady = 1'b1;
      #1;
      chk("flush_no_ready", 64'(ReqReady), 64'd0);
      tick();
      Flush    = 1'b0;
      RspReady = 1'b0;
      ReqValid = '0;
      chk("flush_no_rsp0", 64'(RspValid), 64'd0);
      tick();
      chk("flush_no_rsp1", 64'(RspValid), 64'd0);
      ReqValid = 2'b11;
      #1;
      chk("flush_ptr_kept", 64'(ReqReady), 64'd2);
      tick();
      ReqValid = '0;
      tick();
      chk("flush_after_id", 64'(RspId), 64'd1);

      // Asynchronous reset while a response is pending
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;
      rand_ops();
      ReqA[W-1:0] = 64'h0000_0000_0000_00F0;
      ReqB[1:0]   = 2'b00;
      ReqValid    = 2'b01;
      tick();
      ReqValid = '0;
      tick();
      chk("arst_pre_valid", 64'(RspValid), 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 64'(RspValid), 64'd0);
      chk("arst_res",   RspResult,     64'd0);
      chk("arst_cnt_a", CntA,          64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      do_reset();
      random_phase(3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
